// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage: access-size encodings,
// FSM state enum and small legality/alignment helpers.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic ok;
    case (funct3[1:0])
      2'b01:   ok = !lane[0];
      2'b10:   ok = (lane == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the byte/half at the given lane of a
// read word and sign- or zero-extends it according to funct3.
module load_formatter
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_lane,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      F3_W:    o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: data-memory request/response handshake with pipeline stall, load
// formatting and store strobes. Optional WAIT watchdog enabled by MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [2:0]      in_funct3,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  output logic            stall,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_out,
  output logic [XLEN-1:0] out_ld_data,
  output logic            out_mem_fault,
  output logic            out_bus_err,
  output logic            dmem_req,
  input  logic            dmem_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;
  logic [XLEN-1:0] r_ld_data;
  logic [1:0]      w_lane;
  logic            w_legal;
  logic            w_aligned;
  logic            w_mem_op;
  logic            w_fault;
  logic            w_req;
  logic            w_timeout;
  logic [XLEN-1:0] w_fmt;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  assign out_pc      = in_pc;
  assign out_alu_out = in_alu_out;
  assign out_ld_data = r_ld_data;

  assign w_lane    = in_alu_out[1:0];
  assign w_legal   = f3_legal(in_funct3, in_mem_wr);
  assign w_aligned = addr_aligned(in_funct3, w_lane);
  assign w_mem_op  = in_valid & (in_mem_rd ^ in_mem_wr) & w_legal & w_aligned;
  assign w_fault   = in_valid & (in_mem_rd | in_mem_wr) & ~w_mem_op;

  load_formatter u_load_formatter (
    .i_rdata  (dmem_rdata),
    .i_lane   (w_lane),
    .i_funct3 (in_funct3),
    .o_data   (w_fmt)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  // A response arriving on the terminal cycle still wins over the abort.
  assign w_timeout = ((r_state == REQ) || (r_state == WAIT))
                   && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                   && !((r_state == WAIT) && dmem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == REQ) || (r_state == WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

  assign out_bus_err = r_bus_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign out_bus_err      = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_mem_op;
        if (w_mem_op) w_state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        w_req = 1'b1;
        if (dmem_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid) w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Non-load instructions clear the stale value so MEM/WB never sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_data <= '0;
    end else if (w_timeout) begin
      r_ld_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (!(w_mem_op && in_mem_rd)) r_ld_data <= '0;
        WAIT: if (dmem_rvalid) r_ld_data <= in_mem_rd ? w_fmt : '0;
        default: r_ld_data <= r_ld_data;
      endcase
    end
  end

  always_comb begin
    w_wstrb = 4'h0;
    w_wdata = '0;
    if (in_mem_wr) begin
      case (in_funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << w_lane;
          w_wdata = {4{in_rs2_data[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_lane;
          w_wdata = {2{in_rs2_data[15:0]}};
        end
        default: begin
          w_wstrb = 4'hF;
          w_wdata = in_rs2_data;
        end
      endcase
    end
  end

  // Request drops in the same cycle reset is seen, not one cycle later.
  assign dmem_req      = w_req & ~rst;
  assign dmem_we       = w_req & in_mem_wr;
  assign dmem_addr     = w_req ? {in_alu_out[XLEN-1:2], 2'b00} : '0;
  assign dmem_wstrb    = w_req ? w_wstrb : 4'h0;
  assign dmem_wdata    = w_req ? w_wdata : '0;
  assign out_mem_fault = (r_state == IDLE) & w_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed instructions against a
// schedule-level model of the memory stage; MEM_TIMEOUT_EN adds a watchdog case.
module tb_mem_access_unit;

  localparam int TO = 64;

  logic        clk, rst;
  logic        in_valid, in_mem_rd, in_mem_wr;
  logic [31:0] in_pc, in_alu_out, in_rs2_data;
  logic [2:0]  in_funct3;
  logic        stall, out_mem_fault, out_bus_err;
  logic [31:0] out_pc, out_alu_out, out_ld_data;
  logic        dmem_req, dmem_ready, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_rs2_data(in_rs2_data), .in_funct3(in_funct3),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .stall(stall), .out_pc(out_pc), .out_alu_out(out_alu_out),
    .out_ld_data(out_ld_data), .out_mem_fault(out_mem_fault), .out_bus_err(out_bus_err),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expectations for the current cycle, consumed by the compare process
  logic        e_en = 1'b0;
  logic        e_stall, e_req, e_flt, e_berr, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic [31:0] m_ld = 32'h0;
  logic [31:0] s_ld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(input logic [2:0] f3, input logic st);
    if (st) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [31:0] w, input logic [31:0] a,
                                        input logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'b0001 << (a % 4);
      3'd1:    return 4'b0011 << (a % 4);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    if (e_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      chk("mem_fault", 32'(out_mem_fault), 32'(e_flt));
      chk("bus_err", 32'(out_bus_err), 32'(e_berr));
      chk("ld_data", out_ld_data, m_ld);
      chk("out_pc", out_pc, in_pc);
      chk("out_alu_out", out_alu_out, in_alu_out);
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_strb));
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
    end
  end

  task automatic set_exp(input logic st, input logic rq, input logic fl, input logic be);
    e_en = 1'b1; e_stall = st; e_req = rq; e_flt = fl; e_berr = be;
  endtask

  task automatic tick(inout int nst);
    #2;
    nst += int'(stall);
    s_ld = out_ld_data;
    @(posedge clk);
    #1;
  endtask

  // One instruction held in EX/MEM until it leaves: d_r = ready-low cycles in REQ,
  // d_v = WAIT cycles before rvalid, rst_ph 1/2 = reset in first REQ/WAIT cycle.
  task automatic run(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] rdat,
                     input int d_r, input int d_v, input int rst_ph, input int lit_st,
                     input logic lit_en, input logic [31:0] lit_ld);
    logic        op, flt;
    logic [31:0] eld;
    int          nst;
    op  = v && (rd ^ wr) && m_legal(f3, wr) && m_aligned(f3, a);
    flt = v && (rd || wr) && !op;
    eld = rd ? m_fmt(rdat, a, f3) : 32'h0;
    nst = 0;
    in_valid = v; in_mem_rd = rd; in_mem_wr = wr; in_funct3 = f3;
    in_alu_out = a; in_rs2_data = rs2; in_pc = 32'h0040_0000 + a;
    e_we = wr; e_addr = a & ~32'h3;
    e_strb = wr ? m_strb(f3, a) : 4'h0;
    e_wdata = wr ? m_wdata(f3, rs2) : 32'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555AAAA;
    set_exp(op, 1'b0, flt, 1'b0);
    tick(nst);
    if (!(op && rd)) m_ld = 32'h0;
    dmem_rvalid = 1'b0; dmem_rdata = rdat;
    if (op) begin
      for (int j = 0; j <= d_r; j++) begin
        dmem_ready = (j == d_r);
        rst = (rst_ph == 1);
        set_exp(1'b1, !rst, 1'b0, 1'b0);
        tick(nst);
        if (rst) begin
          rst = 1'b0; m_ld = 32'h0; dmem_ready = 1'b0;
          return;
        end
      end
      dmem_ready = 1'b0;
      for (int j = 0; j <= d_v; j++) begin
        dmem_rvalid = (j == d_v) && (rst_ph != 2);
        rst = (rst_ph == 2);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        tick(nst);
        if (rst) begin
          rst = 1'b0; m_ld = 32'h0; dmem_rvalid = 1'b0;
          return;
        end
      end
      dmem_rvalid = 1'b0;
      m_ld = eld;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      tick(nst);
      if (lit_en) chk("ld_literal", s_ld, lit_ld);
    end
    if (lit_st >= 0) chk("stall_cycles", 32'(nst), 32'(lit_st));
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic run_timeout(input logic [31:0] a);
    int nst;
    nst = 0;
    in_valid = 1'b1; in_mem_rd = 1'b1; in_mem_wr = 1'b0; in_funct3 = 3'd2;
    in_alu_out = a; in_rs2_data = 32'h0; in_pc = 32'h0040_0000 + a;
    e_we = 1'b0; e_addr = a & ~32'h3; e_strb = 4'h0; e_wdata = 32'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    tick(nst);
    dmem_ready = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    tick(nst);
    dmem_ready = 1'b0;
    for (int j = 0; j < TO - 1; j++) begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      tick(nst);
    end
    m_ld = 32'h0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    tick(nst);
    chk("timeout_stall_cycles", 32'(nst), 32'(TO + 1));
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_funct3 = 3'd0;
    in_pc = 32'h0; in_alu_out = 32'h0; in_rs2_data = 32'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state, bubble
    run(0, 0, 0, 3'd0, 32'h0,   32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    // loads
    run(1, 1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 3, 1, 32'hDEADBEEF);
    run(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0, 3, 1, 32'hFFFFFF80);
    run(1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 0, 1, 0, 4, 1, 32'h00000080);
    run(1, 1, 0, 3'd5, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 0, 3, 1, 32'h000080FF);
    run(1, 1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF1234, 2, 0, 0, 5, 1, 32'hFFFF80FF);
    run(1, 1, 0, 3'd1, 32'h100, 32'h0, 32'h80FF1234, 0, 0, 0, 3, 1, 32'h00001234);
    run(1, 1, 0, 3'd0, 32'h101, 32'h0, 32'h80FF1234, 0, 0, 0, 3, 1, 32'h00000012);
    // stores
    run(1, 0, 1, 3'd0, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 0, 0, 0, 3, 1, 32'h0);
    run(1, 0, 1, 3'd1, 32'h102, 32'h1234CAFE, 32'h0, 0, 0, 0, 3, 1, 32'h0);
    run(1, 0, 1, 3'd2, 32'h104, 32'h01234567, 32'h0, 1, 2, 0, 6, 1, 32'h0);
    // ready held low for 4 cycles
    run(1, 1, 0, 3'd2, 32'h100, 32'h0, 32'h0BADF00D, 4, 0, 0, 7, 1, 32'h0BADF00D);
    // faults and pass-through
    run(1, 1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 1, 1, 3'd0, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 0, 0, 3'd2, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    // reset during WAIT after a load left data behind, then stray response
    run(1, 1, 0, 3'd2, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0, 0, 3, 1, 32'hCAFEF00D);
    run(1, 1, 0, 3'd2, 32'h200, 32'h0, 32'h11111111, 0, 3, 2, -1, 0, 32'h0);
    run(0, 0, 0, 3'd0, 32'h0,   32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    // reset during REQ while ready is low
    run(1, 0, 1, 3'd2, 32'h300, 32'hA5A5A5A5, 32'h0, 3, 0, 1, -1, 0, 32'h0);
    run(0, 0, 0, 3'd0, 32'h0,   32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    run(1, 1, 0, 3'd4, 32'h302, 32'h0, 32'h00C30000, 0, 0, 0, 3, 1, 32'h000000C3);
`ifdef MEM_TIMEOUT_EN
    run_timeout(32'h400);
    run(0, 0, 0, 3'd0, 32'h0,   32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
`endif
    e_en = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
